// File: rtl/tile_pkg.sv
// Shared types and default sizing for the falling-tile step sequencer.
package tile_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StShift = 3'd2,
    StCheck = 3'd3,
    StDraw  = 3'd4,
    StOver  = 3'd5
  } state_e;

  localparam int unsigned LANES_DEF   = 4;
  localparam int unsigned ROWS_DEF    = 8;
  localparam int unsigned SCORE_W_DEF = 24;
  localparam int unsigned GRID_W      = LANES_DEF * ROWS_DEF;

endpackage

// File: rtl/lane_grid.sv
// Tile grid shift register with row-0 insertion and bottom-row capture.
// Optional TILE_GAP_EN inserts an empty row on every other shift.
module lane_grid
  import tile_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_shift,
  input  logic [LaneW-1:0]       i_rand_lane,
  output logic [LANES*ROWS-1:0]  o_grid,
  output logic [LANES-1:0]       o_hit_row
);

  logic [LANES*ROWS-1:0] r_grid;
  logic [LANES-1:0]      r_hit_row;
  logic [LANES-1:0]      w_onehot;
  logic [LANES-1:0]      w_row0;

  always_comb begin
    w_onehot              = '0;
    w_onehot[i_rand_lane] = 1'b1;
  end

`ifdef TILE_GAP_EN
  logic r_gap;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gap <= 1'b0;
    end else if (i_clear) begin
      r_gap <= 1'b0;
    end else if (i_shift) begin
      r_gap <= ~r_gap;
    end
  end

  assign w_row0 = r_gap ? '0 : w_onehot;
`else
  assign w_row0 = w_onehot;
`endif

  // Row r lives at bits [r*LANES +: LANES], so moving down a row is a left shift.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grid    <= '0;
      r_hit_row <= '0;
    end else if (i_clear) begin
      r_grid    <= '0;
      r_hit_row <= '0;
    end else if (i_shift) begin
      r_hit_row <= r_grid[LANES*ROWS-1 -: LANES];
      r_grid    <= {r_grid[LANES*(ROWS-1)-1:0], w_row0};
    end
  end

  assign o_grid    = r_grid;
  assign o_hit_row = r_hit_row;

endmodule

// File: rtl/tile_step_ctrl.sv
// Game-step sequencer: wait handshake, grid shift, key judge, score, draw handshake.
// Build option TILE_GAP_EN (see lane_grid) alternates tiles with empty rows.
module tile_step_ctrl
  import tile_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [LANES-1:0]      i_key,
  input  logic [LaneW-1:0]      i_rand_lane,
  input  logic                  i_wait_done,
  output logic                  o_wait_go,
  output logic                  o_draw_req,
  input  logic                  i_draw_ack,
  output logic [LANES*ROWS-1:0] o_grid,
  output logic [SCORE_W-1:0]    o_score,
  output logic                  o_game_over
);

  state_e               r_state, w_state_d;
  logic [LANES-1:0]     r_key_seen, w_key_seen_d;
  logic [SCORE_W-1:0]   r_score, w_score_d;
  logic                 r_wait_go, w_wait_go_d;
  logic                 r_draw_req, w_draw_req_d;
  logic                 r_game_over, w_game_over_d;
  logic                 w_clear;
  logic                 w_shift;
  logic [LANES-1:0]     w_hit_row;

  lane_grid #(
    .LANES (LANES),
    .ROWS  (ROWS)
  ) u_lane_grid (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_rand_lane (i_rand_lane),
    .o_grid      (o_grid),
    .o_hit_row   (w_hit_row)
  );

  always_comb begin
    w_state_d    = r_state;
    w_key_seen_d = r_key_seen;
    w_score_d    = r_score;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      StIdle, StOver: begin
        if (i_start) begin
          w_clear      = 1'b1;
          w_score_d    = '0;
          w_key_seen_d = '0;
          w_state_d    = StWait;
        end
      end
      StWait: begin
        w_key_seen_d = r_key_seen | i_key;
        if (i_wait_done) w_state_d = StShift;
      end
      StShift: begin
        w_shift   = 1'b1;
        w_state_d = StCheck;
      end
      StCheck: begin
        if (w_hit_row == '0) begin
          w_state_d = StDraw;
        end else if (r_key_seen == w_hit_row) begin
          if (r_score != '1) w_score_d = r_score + SCORE_W'(1);
          w_state_d = StDraw;
        end else begin
          w_state_d = StOver;
        end
      end
      StDraw: begin
        if (i_draw_ack) begin
          w_key_seen_d = '0;
          w_state_d    = StWait;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_wait_go_d   = (w_state_d == StWait);
    w_game_over_d = (w_state_d == StOver);
    w_draw_req_d  = 1'b0;
    if (w_state_d == StDraw) begin
      w_draw_req_d = 1'b1;
    end else if (w_state_d == StOver) begin
      // Entering OVER raises the request; once acknowledged it stays down.
      w_draw_req_d = (r_state == StOver) ? (r_draw_req & ~i_draw_ack) : 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_key_seen  <= '0;
      r_score     <= '0;
      r_wait_go   <= 1'b0;
      r_draw_req  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_key_seen  <= w_key_seen_d;
      r_score     <= w_score_d;
      r_wait_go   <= w_wait_go_d;
      r_draw_req  <= w_draw_req_d;
      r_game_over <= w_game_over_d;
    end
  end

  assign o_wait_go   = r_wait_go;
  assign o_draw_req  = r_draw_req;
  assign o_score     = r_score;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_tile_step_ctrl.sv
// Directed bench for tile_step_ctrl (4 lanes, 8 rows, 4-bit score for saturation).
module tb_tile_step_ctrl;

  localparam int unsigned L  = 4;
  localparam int unsigned R  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [L-1:0]  key;
  logic [1:0]    rand_lane;
  logic          wait_done;
  logic          wait_go;
  logic          draw_req;
  logic          draw_ack;
  logic [L*R-1:0] grid;
  logic [SW-1:0] score;
  logic          game_over;

  int n_checks = 0;
  int n_pass   = 0;

  logic [L*R-1:0] m_grid;
  logic [SW-1:0]  m_score;
  bit             m_over;
  bit             m_gap;

  typedef struct {
    logic [1:0]   lane;
    logic [L-1:0] key;
    bit           exp_over;
  } vec_t;

  vec_t tbl[24];

  tile_step_ctrl #(
    .LANES   (L),
    .ROWS    (R),
    .SCORE_W (SW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_key       (key),
    .i_rand_lane (rand_lane),
    .i_wait_done (wait_done),
    .o_wait_go   (wait_go),
    .o_draw_req  (draw_req),
    .i_draw_ack  (draw_ack),
    .o_grid      (grid),
    .o_score     (score),
    .o_game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_clear();
    m_grid  = '0;
    m_score = '0;
    m_over  = 1'b0;
    m_gap   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  // One game step from WAIT; keys are driven high through SHIFT/CHECK to prove they are ignored.
  task automatic step(input logic [1:0] lane, input logic [L-1:0] k, input bit do_ack);
    logic [L-1:0] hit;
    logic [L-1:0] oh;
    int n;
    n = 0;
    while (!wait_go && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_go_high", wait_go, 1);
    rand_lane = lane;
    key       = k;
    repeat (3) @(negedge clk);
    wait_done = 1'b1;
    @(negedge clk);
    wait_done = 1'b0;
    key       = '1;
    chk("wait_go_fall", wait_go, 0);
    oh     = 4'b0001 << lane;
    hit    = m_grid[L*R-1 -: L];
    m_grid = {m_grid[L*(R-1)-1:0], (m_gap ? 4'b0000 : oh)};
`ifdef TILE_GAP_EN
    m_gap = ~m_gap;
`endif
    if (hit != '0) begin
      if (hit == k) begin
        if (m_score != '1) m_score = m_score + 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end
    @(negedge clk);
    chk("grid_after_shift", grid, m_grid);
    chk("draw_req_before_draw", draw_req, 0);
    @(negedge clk);
    key = '0;
    chk("draw_req_rise", draw_req, 1);
    chk("score", score, m_score);
    chk("game_over", game_over, m_over);
    if (do_ack) begin
      draw_ack = 1'b1;
      @(negedge clk);
      draw_ack = 1'b0;
      chk("draw_req_drop", draw_req, 0);
      if (!m_over) chk("wait_go_after_ack", wait_go, 1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    key       = '0;
    rand_lane = '0;
    wait_done = 1'b0;
    draw_ack  = 1'b0;
    model_clear();

    for (int i = 0; i < 24; i++) begin
      tbl[i].lane     = 2'd1;
      tbl[i].key      = 4'b0010;
      tbl[i].exp_over = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("rst_wait_go", wait_go, 0);
    chk("rst_draw_req", draw_req, 0);
    chk("rst_grid", grid, 0);
    chk("rst_score", score, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b0;

    // IDLE ignores wait_done and draw_ack
    wait_done = 1'b1;
    draw_ack  = 1'b1;
    repeat (2) @(negedge clk);
    wait_done = 1'b0;
    draw_ack  = 1'b0;
    chk("idle_wait_go", wait_go, 0);
    chk("idle_draw_req", draw_req, 0);

    // First step, lane 2; stop in DRAW and reset asynchronously
    start_pulse();
    chk("start_wait_go", wait_go, 1);
    step(2'd2, 4'b0000, 1'b0);
    chk("grid_lane2_only", grid, 32'h0000_0004);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_draw_req", draw_req, 0);
    chk("async_rst_grid", grid, 0);
    chk("async_rst_wait_go", wait_go, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("post_rst_idle", wait_go, 0);

    // Long run of hits in lane 1 up to saturation
    start_pulse();
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].lane, tbl[i].key, 1'b1);
      chk("tbl_game_over", game_over, tbl[i].exp_over);
    end
`ifdef TILE_GAP_EN
    chk("score_final", score, 4'd8);
`else
    chk("score_saturated", score, 4'hF);
`endif

    // start is ignored in WAIT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_grid", grid, m_grid);
    chk("start_ignored_score", score, m_score);

    // Miss: lane 3 tile reaches bottom, key 1001 pressed
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_pulse();
    step(2'd3, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) step(2'd0, 4'b0000, 1'b1);
    step(2'd0, 4'b1001, 1'b0);
    chk("miss_game_over", game_over, 1);
    chk("miss_score_unchanged", score, 0);

    // OVER freezes grid/score; draw_req holds until ack
    wait_done = 1'b1;
    repeat (3) @(negedge clk);
    wait_done = 1'b0;
    chk("over_grid_frozen", grid, m_grid);
    chk("over_draw_req_held", draw_req, 1);
    chk("over_game_over_held", game_over, 1);

    // start and draw_ack together: start wins
    draw_ack = 1'b1;
    start_pulse();
    draw_ack = 1'b0;
    chk("restart_wait_go", wait_go, 1);
    chk("restart_draw_req", draw_req, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_grid", grid, 0);
    chk("restart_score", score, 0);

    // Row-0 insertion pattern over four steps with lane 0
    for (int i = 0; i < 4; i++) begin
      step(2'd0, 4'b0000, 1'b1);
`ifdef TILE_GAP_EN
      chk("row0_pattern", grid[3:0], (i % 2 == 0) ? 32'h1 : 32'h0);
`else
      chk("row0_pattern", grid[3:0], 32'h1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
